// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC start-up sequencer: FSM state encoding
// and the width rule used by the loadable phase timer.
package dac_seq_pkg;

  typedef enum logic [2:0] {
    START    = 3'd0,
    DELAY    = 3'd1,
    PULSE_HI = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4
  } seq_state_e;

  // Timer width: must hold the longest value ever loaded, which is at most
  // max(PULSE_PERIOD, START_DELAY).
  function automatic int cnt_width(input int period, input int delay);
    int max_v;
    max_v = (period > delay) ? period : delay;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/dac_seq_timer.sv
// Loadable down-counter shared by the start delay, pulse high time and
// inter-pulse gap. 'done' is high during the last cycle of a loaded
// interval, so the owner changes phase on the edge that ends it.
module dac_seq_timer #(
  parameter int CW = 8
) (
  input  logic          clk12Mhz,
  input  logic          RESET,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt_r;
  logic          done_r;

  // Count down from the loaded value to zero and hold; done_r anticipates
  // the counter reaching one so it is available registered.
  always_ff @(posedge clk12Mhz) begin
    if (RESET) begin
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else if (load) begin
      cnt_r  <= load_val;
      done_r <= (load_val == CW'(1));
    end else if (cnt_r != '0) begin
      cnt_r  <= cnt_r - CW'(1);
      done_r <= (cnt_r == CW'(2));
    end else begin
      cnt_r  <= cnt_r;
      done_r <= 1'b0;
    end
  end

  assign done = done_r;

endmodule

// File: rtl/dac_init_sequencer.sv
// DAC start-up sequencer: after RESET or an accepted re-init request it
// plays N_PULSES init pulses to each DAC channel in turn and raises a
// sticky per-channel ready flag as each channel's train completes.
module dac_init_sequencer
  import dac_seq_pkg::*;
#(
  parameter int N_CH         = 1,
  parameter int N_PULSES     = 3,
  parameter int PULSE_PERIOD = 128,
  parameter int PULSE_WIDTH  = 1,
  parameter int START_DELAY  = 0
) (
  input  logic            clk12Mhz,
  input  logic            RESET,
  input  logic            reinit_req,
  output logic            RESET_out,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] DACReadyFlag,
  output logic            all_ready,
  output logic            busy
);

  localparam int            CW    = cnt_width(PULSE_PERIOD, START_DELAY);
  localparam logic [CW-1:0] PW_C  = CW'(PULSE_WIDTH);
  localparam logic [CW-1:0] GAP_C = CW'(PULSE_PERIOD - PULSE_WIDTH);
  localparam logic [CW-1:0] SD_C  = CW'(START_DELAY);

  seq_state_e      state_r;
  logic [2:0]      ch_r;
  logic [3:0]      pidx_r;
  logic            reset_out_r;
  logic [N_CH-1:0] pulse_r;
  logic [N_CH-1:0] flag_r;
  logic            all_ready_r;
  logic            busy_r;

  logic            tmr_load_s;
  logic [CW-1:0]   tmr_val_s;
  logic            tmr_done_s;
  logic            last_pulse_s;
  logic            last_ch_s;
  logic [2:0]      rise_ch_s;
  logic [N_CH-1:0] rise_onehot_s;
  logic [N_CH-1:0] cur_onehot_s;

  assign last_pulse_s = (pidx_r == 4'(N_PULSES - 1));
  assign last_ch_s    = (ch_r == 3'(N_CH - 1));

  // Channel whose pulse rises next: a gap that follows a channel's last
  // pulse hands over to the following channel.
  always_comb begin
    rise_ch_s = ch_r;
    if ((state_r == GAP) && last_pulse_s) begin
      rise_ch_s = ch_r + 3'd1;
    end else begin
      rise_ch_s = ch_r;
    end
  end

  // One-hot decode of the rising channel and of the current channel.
  always_comb begin
    rise_onehot_s = '0;
    cur_onehot_s  = '0;
    for (int i = 0; i < N_CH; i++) begin
      rise_onehot_s[i] = (rise_ch_s == 3'(i));
      cur_onehot_s[i]  = (ch_r == 3'(i));
    end
  end

  // Timer reload decisions, made on the same edge as the phase change.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    case (state_r)
      START: begin
        tmr_load_s = 1'b1;
        tmr_val_s  = (START_DELAY == 0) ? PW_C : SD_C;
      end
      DELAY: begin
        if (tmr_done_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = PW_C;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      PULSE_HI: begin
        // The final channel's last pulse goes straight to DONE, no gap.
        if (tmr_done_s && !(last_pulse_s && last_ch_s)) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_C;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      GAP: begin
        if (tmr_done_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = PW_C;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
      end
    endcase
  end

  dac_seq_timer #(
    .CW(CW)
  ) u_timer (
    .clk12Mhz(clk12Mhz),
    .RESET   (RESET),
    .load    (tmr_load_s),
    .load_val(tmr_val_s),
    .done    (tmr_done_s)
  );

  // Sequencer FSM with its indices and all registered outputs.
  always_ff @(posedge clk12Mhz) begin
    if (RESET) begin
      state_r     <= START;
      ch_r        <= 3'd0;
      pidx_r      <= 4'd0;
      reset_out_r <= 1'b1;
      pulse_r     <= '0;
      flag_r      <= '0;
      all_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        START: begin
          reset_out_r <= 1'b0;
          busy_r      <= 1'b1;
          ch_r        <= 3'd0;
          pidx_r      <= 4'd0;
          if (START_DELAY == 0) begin
            state_r <= PULSE_HI;
            pulse_r <= rise_onehot_s;
          end else begin
            state_r <= DELAY;
          end
        end
        DELAY: begin
          if (tmr_done_s) begin
            state_r <= PULSE_HI;
            pulse_r <= rise_onehot_s;
          end
        end
        PULSE_HI: begin
          if (tmr_done_s) begin
            pulse_r <= '0;
            if (last_pulse_s) begin
              // Flag rises as the channel's last pulse falls.
              flag_r      <= flag_r | cur_onehot_s;
              all_ready_r <= &(flag_r | cur_onehot_s);
              if (last_ch_s) begin
                state_r <= DONE;
                busy_r  <= 1'b0;
              end else begin
                state_r <= GAP;
              end
            end else begin
              state_r <= GAP;
            end
          end
        end
        GAP: begin
          if (tmr_done_s) begin
            state_r <= PULSE_HI;
            pulse_r <= rise_onehot_s;
            if (last_pulse_s) begin
              ch_r   <= ch_r + 3'd1;
              pidx_r <= 4'd0;
            end else begin
              pidx_r <= pidx_r + 4'd1;
            end
          end
        end
        DONE: begin
          // Re-init behaves like a one-cycle reset; requests while the
          // sequence runs never reach this state and are dropped.
          if (reinit_req) begin
            state_r     <= START;
            ch_r        <= 3'd0;
            pidx_r      <= 4'd0;
            reset_out_r <= 1'b1;
            flag_r      <= '0;
            all_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            pulse_r     <= '0;
          end
        end
        default: begin
          state_r <= START;
        end
      endcase
    end
  end

  assign RESET_out    = reset_out_r;
  assign pulse        = pulse_r;
  assign DACReadyFlag = flag_r;
  assign all_ready    = all_ready_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_dac_init_sequencer.sv
// Self-checking bench for dac_init_sequencer: four parameterisations run in
// lock-step against an arithmetic reference model, plus tabled cycle checks
// and hand-written reset / re-init sequences.
`timescale 1ns/1ps
module tb_dac_init_sequencer;

  localparam int NI = 4;

  logic clk12Mhz = 1'b0;
  logic RESET;
  logic reinit_req;

  always #5 clk12Mhz = ~clk12Mhz;

  logic       ro0, ro1, ro2, ro3;
  logic [0:0] p0, f0, p2, f2;
  logic [1:0] p1, f1;
  logic [2:0] p3, f3;
  logic       ar0, ar1, ar2, ar3;
  logic       bz0, bz1, bz2, bz3;

  dac_init_sequencer u0 (
    .clk12Mhz(clk12Mhz), .RESET(RESET), .reinit_req(reinit_req),
    .RESET_out(ro0), .pulse(p0), .DACReadyFlag(f0), .all_ready(ar0), .busy(bz0)
  );

  dac_init_sequencer #(
    .N_CH(2), .N_PULSES(2), .PULSE_PERIOD(16), .PULSE_WIDTH(3), .START_DELAY(0)
  ) u1 (
    .clk12Mhz(clk12Mhz), .RESET(RESET), .reinit_req(reinit_req),
    .RESET_out(ro1), .pulse(p1), .DACReadyFlag(f1), .all_ready(ar1), .busy(bz1)
  );

  dac_init_sequencer #(
    .START_DELAY(10)
  ) u2 (
    .clk12Mhz(clk12Mhz), .RESET(RESET), .reinit_req(reinit_req),
    .RESET_out(ro2), .pulse(p2), .DACReadyFlag(f2), .all_ready(ar2), .busy(bz2)
  );

  dac_init_sequencer #(
    .N_CH(3), .N_PULSES(2), .PULSE_PERIOD(7), .PULSE_WIDTH(2), .START_DELAY(4)
  ) u3 (
    .clk12Mhz(clk12Mhz), .RESET(RESET), .reinit_req(reinit_req),
    .RESET_out(ro3), .pulse(p3), .DACReadyFlag(f3), .all_ready(ar3), .busy(bz3)
  );

  // Parameters of each instance, as seen by the model.
  int p_nch [NI] = '{1, 2, 1, 3};
  int p_np  [NI] = '{3, 2, 3, 2};
  int p_pp  [NI] = '{128, 16, 128, 7};
  int p_pw  [NI] = '{1, 3, 1, 2};
  int p_sd  [NI] = '{0, 0, 10, 4};

  logic [7:0] a_pulse [NI];
  logic [7:0] a_flag  [NI];
  logic       a_rout  [NI];
  logic       a_all   [NI];
  logic       a_busy  [NI];

  assign a_pulse[0] = {7'd0, p0};
  assign a_pulse[1] = {6'd0, p1};
  assign a_pulse[2] = {7'd0, p2};
  assign a_pulse[3] = {5'd0, p3};
  assign a_flag[0]  = {7'd0, f0};
  assign a_flag[1]  = {6'd0, f1};
  assign a_flag[2]  = {7'd0, f2};
  assign a_flag[3]  = {5'd0, f3};
  assign a_rout[0]  = ro0;
  assign a_rout[1]  = ro1;
  assign a_rout[2]  = ro2;
  assign a_rout[3]  = ro3;
  assign a_all[0]   = ar0;
  assign a_all[1]   = ar1;
  assign a_all[2]   = ar2;
  assign a_all[3]   = ar3;
  assign a_busy[0]  = bz0;
  assign a_busy[1]  = bz1;
  assign a_busy[2]  = bz2;
  assign a_busy[3]  = bz3;

  int checks = 0;
  int errors = 0;

  // Model state: cycles since the last release edge (-1 = held in reset).
  int         n_m [NI];
  bit         model_valid = 1'b0;
  logic [7:0] e_pulse [NI];
  logic [7:0] e_flag  [NI];
  logic       e_rout  [NI];
  logic       e_all   [NI];
  logic       e_busy  [NI];

  typedef struct {
    int         inst;
    int         cyc;
    logic [7:0] pulse;
    logic [7:0] flag;
    logic       all_r;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int tfin(input int i);
    return p_sd[i] + (p_nch[i] * p_np[i] - 1) * p_pp[i] + p_pw[i];
  endfunction

  // Expected outputs n cycles after release, straight from the timing rules.
  task automatic model_expect(input int i, input int n);
    int r;
    e_rout[i]  = 1'b0;
    e_pulse[i] = 8'd0;
    e_flag[i]  = 8'd0;
    for (int c = 0; c < p_nch[i]; c++) begin
      for (int k = 0; k < p_np[i]; k++) begin
        r = p_sd[i] + (c * p_np[i] + k) * p_pp[i];
        if (n >= r && n < r + p_pw[i]) e_pulse[i][c] = 1'b1;
      end
      if (n >= p_sd[i] + (c * p_np[i] + p_np[i] - 1) * p_pp[i] + p_pw[i])
        e_flag[i][c] = 1'b1;
    end
    e_all[i]  = (n >= tfin(i));
    e_busy[i] = (n <  tfin(i));
  endtask

  task automatic model_edge(input logic r, input logic q);
    for (int i = 0; i < NI; i++) begin
      if (r || (q && n_m[i] >= tfin(i))) begin
        n_m[i]     = -1;
        e_rout[i]  = 1'b1;
        e_pulse[i] = 8'd0;
        e_flag[i]  = 8'd0;
        e_all[i]   = 1'b0;
        e_busy[i]  = 1'b0;
      end else begin
        n_m[i] = n_m[i] + 1;
        model_expect(i, n_m[i]);
      end
    end
    if (r) model_valid = 1'b1;
  endtask

  // Drive inputs for one edge, advance the model, then compare all instances.
  task automatic step(input logic r, input logic q);
    RESET      = r;
    reinit_req = q;
    @(posedge clk12Mhz);
    model_edge(r, q);
    #1;
    if (model_valid) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model_u%0d", i),
            {13'd0, a_rout[i], a_pulse[i], a_flag[i], a_all[i], a_busy[i]},
            {13'd0, e_rout[i], e_pulse[i], e_flag[i], e_all[i], e_busy[i]});
      end
    end
  endtask

  task automatic add(input int inst, input int cyc, input logic [7:0] pl,
                     input logic [7:0] fl, input logic al, input logic bs);
    vec_t v;
    v.inst = inst; v.cyc = cyc; v.pulse = pl; v.flag = fl; v.all_r = al; v.busy = bs;
    tbl.push_back(v);
  endtask

  task automatic chk_reset_vals(input string name);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_u%0d", name, i),
          {13'd0, a_rout[i], a_pulse[i], a_flag[i], a_all[i], a_busy[i]},
          {13'd0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) n_m[i] = -1;
    RESET      = 1'b1;
    reinit_req = 1'b0;

    // Cycle-exact expectations taken directly from the documented waveforms.
    add(0, 0,   8'h01, 8'h00, 1'b0, 1'b1);
    add(0, 1,   8'h00, 8'h00, 1'b0, 1'b1);
    add(0, 127, 8'h00, 8'h00, 1'b0, 1'b1);
    add(0, 128, 8'h01, 8'h00, 1'b0, 1'b1);
    add(0, 129, 8'h00, 8'h00, 1'b0, 1'b1);
    add(0, 256, 8'h01, 8'h00, 1'b0, 1'b1);
    add(0, 257, 8'h00, 8'h01, 1'b1, 1'b0);
    add(1, 2,   8'h01, 8'h00, 1'b0, 1'b1);
    add(1, 3,   8'h00, 8'h00, 1'b0, 1'b1);
    add(1, 16,  8'h01, 8'h00, 1'b0, 1'b1);
    add(1, 19,  8'h00, 8'h01, 1'b0, 1'b1);
    add(1, 31,  8'h00, 8'h01, 1'b0, 1'b1);
    add(1, 32,  8'h02, 8'h01, 1'b0, 1'b1);
    add(1, 35,  8'h00, 8'h01, 1'b0, 1'b1);
    add(1, 50,  8'h02, 8'h01, 1'b0, 1'b1);
    add(1, 51,  8'h00, 8'h03, 1'b1, 1'b0);
    add(2, 9,   8'h00, 8'h00, 1'b0, 1'b1);
    add(2, 10,  8'h01, 8'h00, 1'b0, 1'b1);
    add(2, 11,  8'h00, 8'h00, 1'b0, 1'b1);
    add(2, 266, 8'h01, 8'h00, 1'b0, 1'b1);
    add(2, 267, 8'h00, 8'h01, 1'b1, 1'b0);

    // Reset state, then the tabled run from release.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_reset_vals("reset_state");
    for (int c = 0; c < 300; c++) begin
      step(1'b0, 1'b0);
      foreach (tbl[j]) begin
        if (tbl[j].cyc == c) begin
          chk($sformatf("tbl_u%0d_c%0d", tbl[j].inst, c),
              {14'd0, a_rout[tbl[j].inst], a_pulse[tbl[j].inst], a_flag[tbl[j].inst],
               a_all[tbl[j].inst], a_busy[tbl[j].inst]},
              {14'd0, 1'b0, tbl[j].pulse, tbl[j].flag, tbl[j].all_r, tbl[j].busy});
        end
      end
    end

    // Re-init while busy is dropped; re-init in DONE restarts after one RESET_out cycle.
    step(1'b1, 1'b0);
    for (int c = 0; c < 600; c++) begin
      step(1'b0, (c == 51) || (c == 301));
      if (c == 257) chk("reinit_busy_ignored_flag", {31'd0, f0[0]}, 32'd1);
      if (c == 301) chk("reinit_accept", {30'd0, ro0, f0[0]}, {30'd0, 1'b1, 1'b0});
      if (c == 302) chk("reinit_pulse0", {30'd0, ro0, p0[0]}, {30'd0, 1'b0, 1'b1});
      if (c == 430) chk("reinit_pulse1", {31'd0, p0[0]}, 32'd1);
      if (c == 558) chk("reinit_pulse2", {31'd0, p0[0]}, 32'd1);
      if (c == 559) chk("reinit_flag", {30'd0, f0[0], ar0}, {30'd0, 1'b1, 1'b1});
    end

    // RESET in mid-sequence aborts at once; release replays from cycle 0.
    step(1'b1, 1'b0);
    for (int c = 0; c <= 130; c++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("midseq_reset", {29'd0, ro0, p0[0], f0[0]}, {29'd0, 1'b1, 1'b0, 1'b0});
    for (int c = 0; c <= 128; c++) begin
      step(1'b0, 1'b0);
      if (c == 0)   chk("rerun_c0", {30'd0, ro0, p0[0]}, {30'd0, 1'b0, 1'b1});
      if (c == 1)   chk("rerun_c1", {31'd0, p0[0]}, 32'd0);
      if (c == 128) chk("rerun_c128", {31'd0, p0[0]}, 32'd1);
    end

    // RESET and reinit_req together in DONE: reset wins, no extra RESET_out.
    for (int c = 129; c < 270; c++) step(1'b0, 1'b0);
    chk("done_before_collision", {30'd0, f0[0], bz0}, {30'd0, 1'b1, 1'b0});
    step(1'b1, 1'b1);
    chk_reset_vals("reset_and_reinit");
    step(1'b0, 1'b0);
    chk("collision_release_c0", {30'd0, ro0, p0[0]}, {30'd0, 1'b0, 1'b1});
    step(1'b0, 1'b0);
    chk("collision_release_c1", {31'd0, ro0}, 32'd0);

    // Randomized RESET / reinit_req traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
